// File: rtl/fw_pkg.sv
// Shared types for the firewall classifier: latched header, rule entry, FSM state.
package fw_pkg;

  localparam logic ACT_SEND       = 1'b1;
  localparam logic ACT_INVALIDATE = 1'b0;

  typedef struct packed {
    logic [7:0]  protocol;
    logic [31:0] srcip;
    logic [31:0] dstip;
    logic [15:0] srcport;
    logic [15:0] dstport;
  } header_t;

  typedef struct packed {
    logic        en;
    logic [7:0]  protocol;
    logic [31:0] srcip;
    logic [31:0] srcmask;
    logic [31:0] dstip;
    logic [31:0] dstmask;
    logic [15:0] dport_lo;
    logic [15:0] dport_hi;
    logic        action;
  } rule_t;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} fw_state_t;

endpackage

// File: rtl/fw_rule_table.sv
// Rule storage: one write port, asynchronous read by index, enables cleared on reset.
module fw_rule_table
  import fw_pkg::*;
#(
  parameter int NUM_RULES = 8,
  parameter int IDX_W     = $clog2(NUM_RULES)
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  rule_t            i_wr_rule,
  input  logic [IDX_W-1:0] i_rd_idx,
  output rule_t            o_rd_rule
);

  rule_t r_rules [NUM_RULES];

  // Only the enable bits are reset; the remaining fields are don't-care while disabled.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_RULES; i++) r_rules[i].en <= 1'b0;
    end else if (i_we) begin
      r_rules[i_wr_idx] <= i_wr_rule;
    end
  end

  assign o_rd_rule = r_rules[i_rd_idx];

endmodule

// File: rtl/firewall_match.sv
// First-match 5-tuple classifier: scans one rule per cycle and returns a
// send/invalidate verdict tagged with the dispatcher's PRT slot.
//
//   state | meaning
//   IDLE  | ready for a header
//   SCAN  | evaluating rule[r_idx] against the latched header
//   RESP  | verdict held until res_ready
module firewall_match
  import fw_pkg::*;
#(
  parameter int NUM_RULES = 8,
  parameter int TAG_W     = 1,
  parameter int IDX_W     = $clog2(NUM_RULES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hdr_valid,
  output logic             hdr_ready,
  input  logic             hdr_id,
  input  logic [TAG_W-1:0] hdr_tag,
  input  logic [7:0]       hdr_protocol,
  input  logic [31:0]      hdr_srcip,
  input  logic [31:0]      hdr_dstip,
  input  logic [15:0]      hdr_srcport,
  input  logic [15:0]      hdr_dstport,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [7:0]       cfg_protocol,
  input  logic [31:0]      cfg_srcip,
  input  logic [31:0]      cfg_srcmask,
  input  logic [31:0]      cfg_dstip,
  input  logic [31:0]      cfg_dstmask,
  input  logic [15:0]      cfg_dport_lo,
  input  logic [15:0]      cfg_dport_hi,
  input  logic             cfg_action,
  input  logic             default_action,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_result,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_rule_idx,
  output logic             busy
);

  fw_state_t        r_state, w_next_state;
  header_t          r_hdr;
  logic             r_id;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic             r_result;
  logic             r_hit;
  logic [IDX_W-1:0] r_rule_idx;

  rule_t w_cfg_rule, w_rule;
  logic  w_match, w_last, w_accept;
  logic  w_unused_srcport;

  always_comb begin
    w_cfg_rule          = '0;
    w_cfg_rule.en       = cfg_en;
    w_cfg_rule.protocol = cfg_protocol;
    w_cfg_rule.srcip    = cfg_srcip;
    w_cfg_rule.srcmask  = cfg_srcmask;
    w_cfg_rule.dstip    = cfg_dstip;
    w_cfg_rule.dstmask  = cfg_dstmask;
    w_cfg_rule.dport_lo = cfg_dport_lo;
    w_cfg_rule.dport_hi = cfg_dport_hi;
    w_cfg_rule.action   = cfg_action;
  end

  fw_rule_table #(.NUM_RULES(NUM_RULES), .IDX_W(IDX_W)) u_rule_table (
    .clk       (clk),
    .i_rst_n   (rst),
    .i_we      (cfg_we),
    .i_wr_idx  (cfg_idx),
    .i_wr_rule (w_cfg_rule),
    .i_rd_idx  (r_idx),
    .o_rd_rule (w_rule)
  );

  // An inverted port range (lo > hi) fails the two-sided compare and so never matches.
  assign w_match = w_rule.en
                && ((w_rule.protocol == 8'd0) || (w_rule.protocol == r_hdr.protocol))
                && ((r_hdr.srcip & w_rule.srcmask) == (w_rule.srcip & w_rule.srcmask))
                && ((r_hdr.dstip & w_rule.dstmask) == (w_rule.dstip & w_rule.dstmask))
                && (r_hdr.dstport >= w_rule.dport_lo)
                && (r_hdr.dstport <= w_rule.dport_hi);

  assign w_last   = (r_idx == IDX_W'(NUM_RULES - 1));
  assign w_accept = hdr_valid && hdr_ready;

  // Source port is carried in the header record but not used by any rule.
  assign w_unused_srcport = ^r_hdr.srcport;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)          w_next_state = SCAN;
      SCAN:    if (w_match || w_last) w_next_state = RESP;
      RESP:    if (res_ready)         w_next_state = IDLE;
      default:                        w_next_state = IDLE;
    endcase
  end

  always_comb begin
    hdr_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    if (rst) begin
      hdr_ready = (r_state == IDLE);
      res_valid = (r_state == RESP);
      busy      = (r_state != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hdr      <= '0;
      r_id       <= 1'b0;
      r_tag      <= '0;
      r_idx      <= '0;
      r_result   <= 1'b0;
      r_hit      <= 1'b0;
      r_rule_idx <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_hdr.protocol <= hdr_protocol;
          r_hdr.srcip    <= hdr_srcip;
          r_hdr.dstip    <= hdr_dstip;
          r_hdr.srcport  <= hdr_srcport;
          r_hdr.dstport  <= hdr_dstport;
          r_id           <= hdr_id;
          r_tag          <= hdr_tag;
          r_idx          <= '0;
        end
        SCAN: begin
          if (w_match) begin
            r_result   <= w_rule.action;
            r_hit      <= 1'b1;
            r_rule_idx <= r_idx;
          end else if (w_last) begin
            r_result   <= default_action;
            r_hit      <= 1'b0;
            r_rule_idx <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_id       = rst & r_id;
  assign res_tag      = rst ? r_tag : '0;
  assign res_result   = rst & r_result;
  assign res_hit      = rst & r_hit;
  assign res_rule_idx = rst ? r_rule_idx : '0;

endmodule
